// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: safety checker on the roadA/roadB lamp buses.
// Decodes each lamp pair into a signal phase, follows the legal phase
// sequence, enforces min/max dwell times and latches the first fault.
// Ports:
//   clock        system clock, rising edge
//   rst          synchronous active-high reset
//   roadA/roadB  one-hot lamps: 100 green, 010 yellow, 001 red
//   fault        sticky fault flag
//   fault_code   first fault: 1 encoding, 2 conflict, 3 illegal step,
//                4 short dwell, 5 long yellow; 0 none
//   phase        tracked phase: AG=0 AY=1 RR1=2 BG=3 BY=4 RR2=5 SYNC=7
//   cycle_count  completed signal cycles, wraps
module traffic_light_monitor #(
    parameter int CNT_W       = 5,
    parameter int MIN_GREEN_A = 10,
    parameter int MIN_GREEN_B = 12,
    parameter int MIN_YELLOW  = 4,
    parameter int MAX_YELLOW  = 8,
    parameter int MIN_ALLRED  = 2
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [2:0] roadA,
    input  logic [2:0] roadB,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [2:0] phase,
    output logic [7:0] cycle_count
);
    typedef enum logic [2:0] {
        AG   = 3'd0,
        AY   = 3'd1,
        RR1  = 3'd2,
        BG   = 3'd3,
        BY   = 3'd4,
        RR2  = 3'd5,
        SYNC = 3'd7
    } phase_t;

    phase_t           phase_q, phase_d, dec, succ;
    logic [CNT_W-1:0] dwell_q, dwell_d, min_dwell;
    logic [7:0]       cnt_q, cnt_d;
    logic             fault_q;
    logic [2:0]       code_q, viol;
    logic             a_g, a_y, a_r, b_g, b_y, b_r;
    logic             invalid, conflict, in_sync, stay, adv, yellow;

    assign a_g = roadA == 3'b100;
    assign a_y = roadA == 3'b010;
    assign a_r = roadA == 3'b001;
    assign b_g = roadB == 3'b100;
    assign b_y = roadB == 3'b010;
    assign b_r = roadB == 3'b001;

    assign invalid  = !(a_g || a_y || a_r) || !(b_g || b_y || b_r);
    assign conflict = !a_r && !b_r;
    assign in_sync  = phase_q == SYNC;
    assign yellow   = phase_q == AY || phase_q == BY;

    // All-red is ambiguous on its own; the clearance it belongs to follows
    // from which road was last released.
    assign dec = a_g ? AG : a_y ? AY : b_g ? BG : b_y ? BY :
                 (phase_q == AY || phase_q == RR1) ? RR1 : RR2;

    always_comb begin
        succ      = SYNC;
        min_dwell = CNT_W'(MIN_ALLRED);
        case (phase_q)
            AG:      begin succ = AY;  min_dwell = CNT_W'(MIN_GREEN_A); end
            AY:      begin succ = RR1; min_dwell = CNT_W'(MIN_YELLOW);  end
            RR1:     succ = BG;
            BG:      begin succ = BY;  min_dwell = CNT_W'(MIN_GREEN_B); end
            BY:      begin succ = RR2; min_dwell = CNT_W'(MIN_YELLOW);  end
            RR2:     succ = AG;
            default: succ = SYNC;
        endcase
    end

    assign stay = dec == phase_q;
    assign adv  = dec == succ;

    // Highest-priority violation present in this sample.
    assign viol = invalid  ? 3'd1 :
                  conflict ? 3'd2 :
                  (!in_sync && !stay && !adv) ? 3'd3 :
                  (!in_sync && adv && dwell_q < min_dwell) ? 3'd4 :
                  (!in_sync && stay && yellow && dwell_q == CNT_W'(MAX_YELLOW)) ? 3'd5 :
                  3'd0;

    always_comb begin
        phase_d = phase_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        if (!fault_q && viol == 3'd0) begin
            if (in_sync) begin
                if (dec == AG) begin
                    phase_d = AG;
                    dwell_d = CNT_W'(1);
                end
            end else if (adv) begin
                phase_d = dec;
                dwell_d = CNT_W'(1);
                if (phase_q == RR2)
                    cnt_d = cnt_q + 8'd1;
            end else if (dwell_q != '1) begin
                dwell_d = dwell_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            phase_q <= SYNC;
            dwell_q <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            code_q  <= '0;
        end else begin
            phase_q <= phase_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            if (!fault_q && viol != 3'd0) begin
                fault_q <= 1'b1;
                code_q  <= viol;
            end
        end
    end

    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign phase       = phase_q;
    assign cycle_count = cnt_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed and randomized checks against a reference model.
module tb_traffic_light_monitor;
    localparam logic [2:0] G = 3'b100, Y = 3'b010, R = 3'b001;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] roadA = R, roadB = R;
    logic       fault;
    logic [2:0] fault_code, phase;
    logic [7:0] cycle_count;

    int errors = 0, checks = 0;
    int m_ph = 7, m_dw = 0, m_fault = 0, m_code = 0, m_cnt = 0;
    int min_of[6] = '{10, 4, 2, 12, 4, 2};

    always #5 clock = ~clock;

    traffic_light_monitor dut (
        .clock(clock), .rst(rst), .roadA(roadA), .roadB(roadB),
        .fault(fault), .fault_code(fault_code), .phase(phase), .cycle_count(cycle_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit onehot(input logic [2:0] x);
        return x == G || x == Y || x == R;
    endfunction

    // Applies the phase rules to one lamp sample.
    task automatic model(input logic [2:0] a, input logic [2:0] b, input bit r);
        int v, d;
        if (r) begin
            m_ph = 7; m_dw = 0; m_fault = 0; m_code = 0; m_cnt = 0;
            return;
        end
        v = 0;
        d = -1;
        if (!onehot(a) || !onehot(b)) v = 1;
        else if (a != R && b != R) v = 2;
        else begin
            if (a == G) d = 0;
            else if (a == Y) d = 1;
            else if (b == G) d = 3;
            else if (b == Y) d = 4;
            else d = (m_ph == 1 || m_ph == 2) ? 2 : 5;
            if (m_ph != 7) begin
                if (d == m_ph) begin
                    if ((m_ph == 1 || m_ph == 4) && m_dw + 1 > 8) v = 5;
                end else if (d == (m_ph + 1) % 6) begin
                    if (m_dw < min_of[m_ph]) v = 4;
                end else v = 3;
            end
        end
        if (m_fault != 0) return;
        if (v != 0) begin
            m_fault = 1;
            m_code = v;
            return;
        end
        if (m_ph == 7) begin
            if (d == 0) begin m_ph = 0; m_dw = 1; end
        end else if (d == m_ph) begin
            m_dw = (m_dw + 1 > 31) ? 31 : m_dw + 1;
        end else begin
            if (m_ph == 5) m_cnt = (m_cnt + 1) % 256;
            m_ph = d;
            m_dw = 1;
        end
    endtask

    task automatic cyc(input logic [2:0] a, input logic [2:0] b, input bit r = 1'b0);
        @(negedge clock);
        roadA = a;
        roadB = b;
        rst = r;
        @(posedge clock);
        model(a, b, r);
        #1;
        check("phase", phase, m_ph);
        check("fault", fault, m_fault);
        check("fault_code", fault_code, m_code);
        check("cycle_count", cycle_count, m_cnt);
    endtask

    task automatic hold(input logic [2:0] a, input logic [2:0] b, input int n);
        repeat (n) cyc(a, b);
    endtask

    // Holds a pair for n samples, occasionally corrupting one sample.
    task automatic seg(input logic [2:0] a, input logic [2:0] b, input int n);
        repeat (n) begin
            if ($urandom_range(59, 0) == 0) cyc(3'($urandom), 3'($urandom));
            else cyc(a, b);
        end
    endtask

    initial begin
        cyc(R, R, 1'b1);
        check("rst_phase", phase, 7);
        check("rst_fault", fault, 0);
        check("rst_code", fault_code, 0);
        check("rst_count", cycle_count, 0);

        hold(G, R, 11); hold(Y, R, 5); hold(R, R, 2);
        hold(R, G, 13); hold(R, Y, 5); hold(R, R, 2);
        check("full_cycle_phase", phase, 5);
        check("full_cycle_pre", cycle_count, 0);
        cyc(G, R);
        check("full_cycle_count", cycle_count, 1);
        check("full_cycle_nofault", fault, 0);

        cyc(G, Y);
        check("conflict_code", fault_code, 2);
        check("conflict_frozen", phase, 0);

        cyc(R, R, 1'b1);
        cyc(3'b110, R);
        check("encoding_code", fault_code, 1);
        cyc(G, G);
        check("sticky_code", fault_code, 1);

        cyc(R, R, 1'b1);
        hold(G, R, 11); hold(Y, R, 3); cyc(R, R);
        check("short_yellow", fault_code, 4);

        cyc(R, R, 1'b1);
        hold(G, R, 11); hold(Y, R, 8);
        check("yellow_8_ok", fault, 0);
        cyc(Y, R);
        check("long_yellow", fault_code, 5);

        cyc(R, R, 1'b1);
        hold(G, R, 11); cyc(R, R);
        check("illegal_step", fault_code, 3);
        cyc(R, R, 1'b1);
        check("rerst_fault", fault, 0);
        check("rerst_code", fault_code, 0);
        hold(R, R, 2);
        check("sync_hold", phase, 7);
        cyc(G, R);
        check("relock", phase, 0);

        for (int k = 0; k < 30; k++) begin
            if (fault || $urandom_range(7, 0) == 0) cyc(R, R, 1'b1);
            seg(G, R, $urandom_range(13, 9));
            seg(Y, R, $urandom_range(9, 3));
            seg(R, R, $urandom_range(3, 1));
            seg(R, G, $urandom_range(14, 11));
            seg(R, Y, $urandom_range(9, 3));
            seg(R, R, $urandom_range(3, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
